// File: rtl/score_requant_stage.sv
// score_requant_stage: requantizes 18-bit MAC scores to 8 bits and buffers them in a credit-flow FIFO.
// Define SCORE_ROUND_EN for round-half-up before the shift; otherwise scores are truncated.
module score_requant_stage #(
    parameter int DEPTH = 4,
    parameter int SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [17:0] acc_in,
    input  logic        acc_vld_in,
    output logic        credit_out,
    output logic [7:0]  score_mst_out,
    output logic        vld_mst_out,
    input  logic        rdy_mst_in,
    output logic        ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] init_cnt, init_cnt_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    mem [DEPTH];
    logic [18:0]   t, s;
    logic [7:0]    score;
    logic          pop, push, credit_nxt;

`ifdef SCORE_ROUND_EN
    assign t = {1'b0, acc_in} + 19'(1 << (SHIFT - 1));
`else
    assign t = {1'b0, acc_in};
`endif
    assign s     = t >> SHIFT;
    assign score = (s > 19'd255) ? 8'hFF : s[7:0];

    assign vld_mst_out   = (count != '0);
    assign score_mst_out = mem[rd_ptr];
    assign pop           = vld_mst_out & rdy_mst_in;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push          = acc_vld_in & ((count < CW'(DEPTH)) | pop);

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        credit_nxt   = pop;
        if (state == INIT) begin
            credit_nxt   = 1'b1;
            init_cnt_nxt = init_cnt + 1'b1;
            state_nxt    = (init_cnt == AW'(DEPTH - 1)) ? RUN : INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= INIT;
            init_cnt   <= '0;
            credit_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            init_cnt   <= init_cnt_nxt;
            credit_out <= credit_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= score;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (acc_vld_in && !push) ovf_err <= 1'b1;
        end
    end
endmodule
